// File: rtl/fetch_redirect_ctrl.sv
// fetch_redirect_ctrl: picks the next-PC source from ID/EX control-flow outcomes and flushes wrong-path fetch slots.
// Latency: zero -- pc_sel and flush follow a request in the same cycle; the PC takes it at the next unstalled edge.
// Backpressure: stall freezes the PC, so a redirect is latched (redirect_pending) and replayed when stall drops.
//
// Ports:
//   clk, rst          core clock, synchronous active-high reset
//   stall             fetch PC register frozen this cycle
//   id_valid/id_is_jal                    decode-stage JAL
//   ex_valid/ex_is_jalr/ex_is_branch/ex_br_taken  execute-stage outcome
//   pc_sel            0 = PC+imm (JAL), 1 = ALU target, 2 = PC+4
//   flush             kill fetch/decode slots this cycle
//   redirect_pending  a redirect is latched and waiting for stall to drop
//   stat_jal/stat_branch/stat_jalr  accepted-redirect counters (only with REDIRECT_STATS_EN)
//
// Optional feature macro: REDIRECT_STATS_EN.

module fetch_redirect_ctrl #(
  parameter int FLUSH_DEPTH     = 2,
  parameter int JAL_FLUSH_DEPTH = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        id_valid,
  input  logic        id_is_jal,
  input  logic        ex_valid,
  input  logic        ex_is_jalr,
  input  logic        ex_is_branch,
  input  logic        ex_br_taken,
  output logic [1:0]  pc_sel,
  output logic        flush,
  output logic        redirect_pending
`ifdef REDIRECT_STATS_EN
  ,
  output logic [31:0] stat_jal,
  output logic [31:0] stat_branch,
  output logic [31:0] stat_jalr
`endif
);

  // Depth is held in a 3-bit counter; reject anything that cannot be represented.
  if (FLUSH_DEPTH < 1 || FLUSH_DEPTH > 7) begin : g_bad_flush_depth
    $error("fetch_redirect_ctrl: FLUSH_DEPTH must be in 1..7");
  end
  if (JAL_FLUSH_DEPTH < 1 || JAL_FLUSH_DEPTH > 7) begin : g_bad_jal_flush_depth
    $error("fetch_redirect_ctrl: JAL_FLUSH_DEPTH must be in 1..7");
  end

  localparam logic [2:0] EX_RELOAD  = 3'(FLUSH_DEPTH - 1);
  localparam logic [2:0] JAL_RELOAD = 3'(JAL_FLUSH_DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_PENDING, S_FLUSH} state_t;
  // Branch and JALR share pc_sel=1 but are kept apart so the stats can tell them apart.
  typedef enum logic [1:0] {K_NONE, K_JAL, K_BR, K_JALR} kind_t;

  state_t     state, state_nxt;
  kind_t      pend_kind, pend_kind_nxt;
  logic [2:0] cnt, cnt_nxt;

  logic  ex_req, id_req, flush_active;
  kind_t ex_kind, cur_kind;
  logic  apply;

  // Request decode and the redirect kind driven this cycle.
  always_comb begin
    flush_active = (state == S_FLUSH);
    ex_req       = ex_valid & (ex_is_jalr | (ex_is_branch & ex_br_taken));
    id_req       = id_valid & id_is_jal & ~flush_active;
    ex_kind      = ex_is_jalr ? K_JALR : K_BR;
    cur_kind     = K_NONE;
    case (state)
      // An older EX redirect replaces a latched JAL; a latched EX redirect is never replaced,
      // since under stall the EX instruction is the same one that was latched.
      S_PENDING: cur_kind = (ex_req && pend_kind == K_JAL) ? ex_kind : pend_kind;
      default:   cur_kind = ex_req ? ex_kind : (id_req ? K_JAL : K_NONE);
    endcase
    apply = (cur_kind != K_NONE) & ~stall;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      pend_kind <= K_NONE;
      cnt       <= 3'd0;
    end else begin
      state     <= state_nxt;
      pend_kind <= pend_kind_nxt;
      cnt       <= cnt_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt     = state;
    pend_kind_nxt = pend_kind;
    cnt_nxt       = cnt;
    if (cur_kind != K_NONE) begin
      if (stall) begin
        state_nxt     = S_PENDING;
        pend_kind_nxt = cur_kind;
      end else begin
        cnt_nxt       = (cur_kind == K_JAL) ? JAL_RELOAD : EX_RELOAD;
        state_nxt     = (cnt_nxt != 3'd0) ? S_FLUSH : S_IDLE;
        pend_kind_nxt = K_NONE;
      end
    end else if (state == S_FLUSH && !stall) begin
      // The counter only moves on unstalled cycles so every flush slot is a real fetch slot.
      cnt_nxt = (cnt != 3'd0) ? cnt - 3'd1 : 3'd0;
      if (cnt <= 3'd1) state_nxt = S_IDLE;
    end
  end

  // Output logic.
  always_comb begin
    case (cur_kind)
      K_JAL:         pc_sel = 2'd0;
      K_BR, K_JALR:  pc_sel = 2'd1;
      default:       pc_sel = 2'd2;
    endcase
    flush            = (state != S_IDLE) | (cur_kind != K_NONE);
    redirect_pending = (state == S_PENDING);
  end

`ifdef REDIRECT_STATS_EN
  // Counted once per redirect, on the cycle the PC actually takes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_jal    <= 32'd0;
      stat_branch <= 32'd0;
      stat_jalr   <= 32'd0;
    end else if (apply) begin
      if (cur_kind == K_JAL)  stat_jal    <= stat_jal + 32'd1;
      if (cur_kind == K_BR)   stat_branch <= stat_branch + 32'd1;
      if (cur_kind == K_JALR) stat_jalr   <= stat_jalr + 32'd1;
    end
  end
`else
  logic unused_apply;
  assign unused_apply = apply;
`endif

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Directed bench for fetch_redirect_ctrl with default depths (FLUSH_DEPTH=2, JAL_FLUSH_DEPTH=1).
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_fetch_redirect_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       stall, id_valid, id_is_jal, ex_valid, ex_is_jalr, ex_is_branch, ex_br_taken;
  logic [1:0] pc_sel;
  logic       flush, redirect_pending;
`ifdef REDIRECT_STATS_EN
  logic [31:0] stat_jal, stat_branch, stat_jalr;
`endif

  int passed = 0;
  int total  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  fetch_redirect_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .stall            (stall),
    .id_valid         (id_valid),
    .id_is_jal        (id_is_jal),
    .ex_valid         (ex_valid),
    .ex_is_jalr       (ex_is_jalr),
    .ex_is_branch     (ex_is_branch),
    .ex_br_taken      (ex_br_taken),
    .pc_sel           (pc_sel),
    .flush            (flush),
    .redirect_pending (redirect_pending)
`ifdef REDIRECT_STATS_EN
    ,
    .stat_jal         (stat_jal),
    .stat_branch      (stat_branch),
    .stat_jalr        (stat_jalr)
`endif
  );

  // Drive one cycle of inputs: stall, id JAL, ex JALR, ex taken branch, ex not-taken branch.
  task automatic drive(input logic s, input logic jal, input logic jalr,
                       input logic br_tk, input logic br_nt);
    stall        = s;
    id_valid     = jal;
    id_is_jal    = jal;
    ex_valid     = jalr | br_tk | br_nt;
    ex_is_jalr   = jalr;
    ex_is_branch = br_tk | br_nt;
    ex_br_taken  = br_tk;
  endtask

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Sample outputs mid-cycle, then advance to just after the next rising edge.
  task automatic step(input string tag, input logic [1:0] e_sel, input logic e_fl, input logic e_pd);
    @(negedge clk);
    cmp({tag, ".pc_sel"}, {30'd0, pc_sel}, {30'd0, e_sel});
    cmp({tag, ".flush"}, {31'd0, flush}, {31'd0, e_fl});
    cmp({tag, ".pending"}, {31'd0, redirect_pending}, {31'd0, e_pd});
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    // Reset held for two cycles, then idle.
    step("reset", 2, 0, 0);
    rst = 1'b0;
    step("idle0", 2, 0, 0);
    step("idle1", 2, 0, 0);

    // Taken branch: redirect now, flush for two unstalled cycles.
    drive(0, 0, 0, 1, 0); step("br.req", 1, 1, 0);
    drive(0, 0, 0, 0, 0); step("br.fl1", 2, 1, 0);
    step("br.done", 2, 0, 0);
    // Not-taken branch: nothing happens.
    drive(0, 0, 0, 0, 1); step("nt.req", 2, 0, 0);
    drive(0, 0, 0, 0, 0); step("nt.after", 2, 0, 0);

    // JAL in ID together with JALR in EX: EX wins, the JAL is not redirected afterwards.
    drive(0, 1, 1, 0, 0); step("pri.req", 1, 1, 0);
    drive(0, 1, 0, 0, 0); step("pri.jal_supp", 2, 1, 0);
    drive(0, 0, 0, 0, 0); step("pri.done", 2, 0, 0);

    // Lone JAL: pc_sel=0, one flush cycle.
    drive(0, 1, 0, 0, 0); step("jal.req", 0, 1, 0);
    drive(0, 0, 0, 0, 0); step("jal.done", 2, 0, 0);

    // Taken branch under a 3-cycle stall, then release.
    drive(1, 0, 0, 1, 0); step("stl.c0", 1, 1, 0);
    step("stl.c1", 1, 1, 1);
    step("stl.c2", 1, 1, 1);
    drive(0, 0, 0, 0, 0); step("stl.release", 1, 1, 1);
    step("stl.fl2", 2, 1, 0);
    step("stl.done", 2, 0, 0);

    // JAL during FLUSH is suppressed.
    drive(0, 0, 0, 1, 0); step("fj.br", 1, 1, 0);
    drive(0, 1, 0, 0, 0); step("fj.jal", 2, 1, 0);
    drive(0, 0, 0, 0, 0); step("fj.done", 2, 0, 0);

    // Taken branch during FLUSH restarts the flush length.
    drive(0, 0, 0, 1, 0); step("fb.br0", 1, 1, 0);
    drive(0, 0, 0, 1, 0); step("fb.br1", 1, 1, 0);
    drive(0, 0, 0, 0, 0); step("fb.fl", 2, 1, 0);
    step("fb.done", 2, 0, 0);

    // Stall inside FLUSH freezes the counter.
    drive(0, 0, 0, 1, 0); step("fs.br", 1, 1, 0);
    drive(1, 0, 0, 0, 0); step("fs.stall0", 2, 1, 0);
    step("fs.stall1", 2, 1, 0);
    drive(0, 0, 0, 0, 0); step("fs.fl", 2, 1, 0);
    step("fs.done", 2, 0, 0);

    // Latched JAL overwritten by a later EX redirect while stalled.
    drive(1, 1, 0, 0, 0); step("ow.jal", 0, 1, 0);
    drive(1, 0, 1, 0, 0); step("ow.jalr", 1, 1, 1);
    drive(1, 0, 0, 0, 0); step("ow.hold", 1, 1, 1);
    drive(0, 0, 0, 0, 0); step("ow.release", 1, 1, 1);
    step("ow.fl2", 2, 1, 0);
    step("ow.done", 2, 0, 0);

    // Reset while PENDING under stall.
    drive(1, 0, 0, 1, 0); step("rp.br", 1, 1, 0);
    step("rp.pend", 1, 1, 1);
    rst = 1'b1;
    drive(1, 0, 0, 0, 0); step("rp.rst_cycle", 1, 1, 1);
    rst = 1'b0;
    drive(0, 0, 0, 0, 0); step("rp.after0", 2, 0, 0);
    step("rp.after1", 2, 0, 0);

    // Five JALs then three taken branches.
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 0, 0, 0); step("cnt.jal", 0, 1, 0);
    end
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 1, 0); step("cnt.br", 1, 1, 0);
      drive(0, 0, 0, 0, 0); step("cnt.fl", 2, 1, 0);
    end
    step("cnt.done", 2, 0, 0);
`ifdef REDIRECT_STATS_EN
    cmp("stat_jal", stat_jal, 32'd5);
    cmp("stat_branch", stat_branch, 32'd3);
    cmp("stat_jalr", stat_jalr, 32'd0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
